// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite register-file write slice:
//   RESP_OKAY / RESP_SLVERR : B-channel response codes
//   axil_wr_state_e         : write-path FSM state type
//   idx_width()             : register index width, never below 1 bit
// -----------------------------------------------------------------------------
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GOT_AW = 2'd1,
      GOT_W  = 2'd2,
      RESP   = 2'd3
   } axil_wr_state_e;

   // A single-register file still needs a 1-bit index signal.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axil_regfile_decode.sv
// -----------------------------------------------------------------------------
// axil_regfile_decode
// Purely combinational byte-address to register-index decode.
//   i_addr  : byte address from the AW channel
//   o_idx   : register index = (i_addr - BASE_ADDR) >> log2(DATA_WIDTH/8)
//   o_valid : address is at/above BASE_ADDR, word aligned and inside the file
// -----------------------------------------------------------------------------
module axil_regfile_decode
   import axil_pkg::*;
#(
   parameter int unsigned              ADDR_WIDTH = 32,
   parameter int unsigned              DATA_WIDTH = 32,
   parameter int unsigned              NUM_REGS   = 16,
   parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = '0,
   parameter int unsigned              IDX_W      = idx_width(NUM_REGS)
) (
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [IDX_W-1:0]      o_idx,
   output logic                  o_valid
);

   localparam int unsigned            LSB        = $clog2(DATA_WIDTH / 8);
   localparam logic [ADDR_WIDTH:0]    BASE_EXT   = {1'b0, BASE_ADDR};
   localparam logic [ADDR_WIDTH:0]    COUNT_EXT  = (ADDR_WIDTH + 1)'(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0]  ALIGN_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

   logic [ADDR_WIDTH:0] w_offset;
   logic [ADDR_WIDTH:0] w_word;

   // One extra bit on the subtraction: a set MSB means the address was below
   // BASE_ADDR, so low addresses cannot wrap into the register range.
   assign w_offset = {1'b0, i_addr} - BASE_EXT;
   assign w_word   = w_offset >> LSB;
   assign o_idx    = w_word[IDX_W-1:0];
   assign o_valid  = !w_offset[ADDR_WIDTH]
                     && (w_word < COUNT_EXT)
                     && ((i_addr & ALIGN_MASK) == '0);

endmodule

// File: rtl/axil_regfile_wr.sv
// -----------------------------------------------------------------------------
// axil_regfile_wr
// AXI4-Lite write-only slave in front of a flat register file.
//   aclk, aresetn        : clock, asynchronous active-low reset
//   s_axil_aw*           : write address channel (byte address)
//   s_axil_w*            : write data channel with byte strobes
//   s_axil_b*            : write response channel
//   reg_o[NUM_REGS]      : current register contents
//   wr_pulse_o           : one-cycle one-hot strobe per register written
// AW and W may arrive in either order or together; the write, the pulse and
// bvalid all happen on the edge that completes the second handshake.
// Build option: define AXIL_REGFILE_WR_SLVERR_EN to answer invalid accesses
// with SLVERR instead of OKAY (they are dropped either way).
// -----------------------------------------------------------------------------
module axil_regfile_wr
   import axil_pkg::*;
#(
   parameter int unsigned                 AXI_DATA_WIDTH = 32,
   parameter int unsigned                 AXI_ADDR_WIDTH = 32,
   parameter int unsigned                 NUM_REGS       = 16,
   parameter logic [AXI_ADDR_WIDTH-1:0]   BASE_ADDR      = '0
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic [AXI_ADDR_WIDTH-1:0]       s_axil_awaddr,
   input  logic                            s_axil_awvalid,
   output logic                            s_axil_awready,
   input  logic [AXI_DATA_WIDTH-1:0]       s_axil_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]     s_axil_wstrb,
   input  logic                            s_axil_wvalid,
   output logic                            s_axil_wready,
   output logic [1:0]                      s_axil_bresp,
   output logic                            s_axil_bvalid,
   input  logic                            s_axil_bready,
   output logic [AXI_DATA_WIDTH-1:0]       reg_o [NUM_REGS],
   output logic [NUM_REGS-1:0]             wr_pulse_o
);

   localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
   localparam int unsigned IDX_W  = idx_width(NUM_REGS);

   axil_wr_state_e r_state;
   axil_wr_state_e w_state_nxt;

   logic                        r_awready;
   logic                        r_wready;
   logic                        r_bvalid;
   logic [1:0]                  r_bresp;
   logic [AXI_ADDR_WIDTH-1:0]   r_awaddr;
   logic [AXI_DATA_WIDTH-1:0]   r_wdata;
   logic [STRB_W-1:0]           r_wstrb;
   logic [AXI_DATA_WIDTH-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0]         r_wr_pulse;

   logic                        w_aw_hs;
   logic                        w_w_hs;
   logic                        w_commit;
   logic [AXI_ADDR_WIDTH-1:0]   w_awaddr_eff;
   logic [AXI_DATA_WIDTH-1:0]   w_wdata_eff;
   logic [STRB_W-1:0]           w_wstrb_eff;
   logic [IDX_W-1:0]            w_dec_idx;
   logic                        w_dec_valid;
   logic [1:0]                  w_bresp_nxt;
   logic [NUM_REGS-1:0]         w_wr_sel;

   assign w_aw_hs = s_axil_awvalid && r_awready;
   assign w_w_hs  = s_axil_wvalid && r_wready;

   // On the completing edge one side comes straight off the bus (its holding
   // register is not loaded yet), so select live vs. held per channel.
   assign w_awaddr_eff = w_aw_hs ? s_axil_awaddr : r_awaddr;
   assign w_wdata_eff  = w_w_hs  ? s_axil_wdata  : r_wdata;
   assign w_wstrb_eff  = w_w_hs  ? s_axil_wstrb  : r_wstrb;

   axil_regfile_decode #(
      .ADDR_WIDTH (AXI_ADDR_WIDTH),
      .DATA_WIDTH (AXI_DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .BASE_ADDR  (BASE_ADDR),
      .IDX_W      (IDX_W)
   ) u_decode (
      .i_addr  (w_awaddr_eff),
      .o_idx   (w_dec_idx),
      .o_valid (w_dec_valid)
   );

`ifdef AXIL_REGFILE_WR_SLVERR_EN
   assign w_bresp_nxt = w_dec_valid ? RESP_OKAY : RESP_SLVERR;
`else
   assign w_bresp_nxt = RESP_OKAY;
`endif

   // Next-state and commit decode
   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_aw_hs && w_w_hs) begin
               w_state_nxt = RESP;
               w_commit    = 1'b1;
            end else if (w_aw_hs) begin
               w_state_nxt = GOT_AW;
            end else if (w_w_hs) begin
               w_state_nxt = GOT_W;
            end
         end
         GOT_AW: begin
            if (w_w_hs) begin
               w_state_nxt = RESP;
               w_commit    = 1'b1;
            end
         end
         GOT_W: begin
            if (w_aw_hs) begin
               w_state_nxt = RESP;
               w_commit    = 1'b1;
            end
         end
         RESP: begin
            if (r_bvalid && s_axil_bready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Per-register write select; an all-zero strobe selects nothing
   always_comb begin
      w_wr_sel = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         w_wr_sel[r] = w_commit && w_dec_valid && (|w_wstrb_eff)
                       && (w_dec_idx == IDX_W'(r));
      end
   end

   // State register; readies are registered from the next state
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state   <= IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_awready <= (w_state_nxt == IDLE) || (w_state_nxt == GOT_W);
         r_wready  <= (w_state_nxt == IDLE) || (w_state_nxt == GOT_AW);
      end
   end

   // Holding registers for whichever channel handshakes first
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_awaddr <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
      end else begin
         if (w_aw_hs) begin
            r_awaddr <= s_axil_awaddr;
         end
         if (w_w_hs) begin
            r_wdata <= s_axil_wdata;
            r_wstrb <= s_axil_wstrb;
         end
      end
   end

   // Response channel; bresp only changes on a commit so it is stable while stalled
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
      end else if (w_commit) begin
         r_bvalid <= 1'b1;
         r_bresp  <= w_bresp_nxt;
      end else if (r_bvalid && s_axil_bready) begin
         r_bvalid <= 1'b0;
      end
   end

   // Register file with byte-lane merge, plus the write pulse
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            r_regs[r] <= '0;
         end
         r_wr_pulse <= '0;
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
               if (w_wr_sel[r] && w_wstrb_eff[b]) begin
                  r_regs[r][8*b +: 8] <= w_wdata_eff[8*b +: 8];
               end
            end
         end
         r_wr_pulse <= w_wr_sel;
      end
   end

   assign s_axil_awready = r_awready;
   assign s_axil_wready  = r_wready;
   assign s_axil_bvalid  = r_bvalid;
   assign s_axil_bresp   = r_bresp;
   assign reg_o          = r_regs;
   assign wr_pulse_o     = r_wr_pulse;

endmodule

// File: tb/tb_axil_regfile_wr.sv
// -----------------------------------------------------------------------------
// tb_axil_regfile_wr
// Directed bench for axil_regfile_wr with default parameters (32-bit data,
// 16 registers at base 0). Expected bresp for invalid accesses follows
// AXIL_REGFILE_WR_SLVERR_EN.
// -----------------------------------------------------------------------------
module tb_axil_regfile_wr;

   logic        aclk;
   logic        aresetn;
   logic [31:0] s_axil_awaddr;
   logic        s_axil_awvalid;
   logic        s_axil_awready;
   logic [31:0] s_axil_wdata;
   logic [3:0]  s_axil_wstrb;
   logic        s_axil_wvalid;
   logic        s_axil_wready;
   logic [1:0]  s_axil_bresp;
   logic        s_axil_bvalid;
   logic        s_axil_bready;
   logic [31:0] reg_o [16];
   logic [15:0] wr_pulse_o;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

`ifdef AXIL_REGFILE_WR_SLVERR_EN
   localparam logic [1:0] EXP_BAD = 2'b10;
`else
   localparam logic [1:0] EXP_BAD = 2'b00;
`endif

   axil_regfile_wr #(
      .AXI_DATA_WIDTH (32),
      .AXI_ADDR_WIDTH (32),
      .NUM_REGS       (16),
      .BASE_ADDR      (32'h0)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .s_axil_awaddr  (s_axil_awaddr),
      .s_axil_awvalid (s_axil_awvalid),
      .s_axil_awready (s_axil_awready),
      .s_axil_wdata   (s_axil_wdata),
      .s_axil_wstrb   (s_axil_wstrb),
      .s_axil_wvalid  (s_axil_wvalid),
      .s_axil_wready  (s_axil_wready),
      .s_axil_bresp   (s_axil_bresp),
      .s_axil_bvalid  (s_axil_bvalid),
      .s_axil_bready  (s_axil_bready),
      .reg_o          (reg_o),
      .wr_pulse_o     (wr_pulse_o)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one edge, then settle past the NBA region
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   initial begin
      aresetn        = 1'b0;
      s_axil_awaddr  = '0;
      s_axil_awvalid = 1'b0;
      s_axil_wdata   = '0;
      s_axil_wstrb   = '0;
      s_axil_wvalid  = 1'b0;
      s_axil_bready  = 1'b0;

      // ---- reset state ----
      tick();
      tick();
      check("rst_awready", s_axil_awready, 0);
      check("rst_wready",  s_axil_wready,  0);
      check("rst_bvalid",  s_axil_bvalid,  0);
      check("rst_bresp",   s_axil_bresp,   0);
      check("rst_pulse",   wr_pulse_o,     0);
      for (int i = 0; i < 16; i++) check("rst_reg", reg_o[i], 0);
      aresetn = 1'b1;
      #1;
      check("rel_awready_pre", s_axil_awready, 0);
      tick();
      check("rel_awready", s_axil_awready, 1);
      check("rel_wready",  s_axil_wready,  1);

      // ---- simultaneous AW + W to 0x8 ----
      s_axil_awaddr = 32'h8;  s_axil_awvalid = 1'b1;
      s_axil_wdata  = 32'hDEADBEEF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
      tick();
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      check("sim_bvalid",  s_axil_bvalid,  1);
      check("sim_bresp",   s_axil_bresp,   2'b00);
      check("sim_reg2",    reg_o[2],       32'hDEADBEEF);
      check("sim_pulse",   wr_pulse_o,     16'h0004);
      check("sim_awready", s_axil_awready, 0);
      check("sim_wready",  s_axil_wready,  0);
      s_axil_bready = 1'b1;
      tick();
      s_axil_bready = 1'b0;
      check("sim_pulse_off", wr_pulse_o,     16'h0000);
      check("sim_b_done",    s_axil_bvalid,  0);
      check("sim_idle_aw",   s_axil_awready, 1);

      // ---- W three cycles before AW to 0x0, strb 4'h3 ----
      s_axil_wdata = 32'h12345678; s_axil_wstrb = 4'h3; s_axil_wvalid = 1'b1;
      tick();
      s_axil_wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("gotw_awready", s_axil_awready, 1);
         check("gotw_wready",  s_axil_wready,  0);
         check("gotw_bvalid",  s_axil_bvalid,  0);
         if (i < 2) tick();
      end
      s_axil_awaddr = 32'h0; s_axil_awvalid = 1'b1;
      tick();
      s_axil_awvalid = 1'b0;
      check("wfirst_bvalid", s_axil_bvalid, 1);
      check("wfirst_bresp",  s_axil_bresp,  2'b00);
      check("wfirst_reg0",   reg_o[0],      32'h00005678);
      check("wfirst_pulse",  wr_pulse_o,    16'h0001);
      check("wfirst_reg2",   reg_o[2],      32'hDEADBEEF);
      s_axil_bready = 1'b1;
      tick();
      s_axil_bready = 1'b0;

      // ---- out of range 0x40 ----
      s_axil_awaddr = 32'h40; s_axil_awvalid = 1'b1;
      s_axil_wdata  = 32'hFFFFFFFF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
      tick();
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      check("oor_bvalid", s_axil_bvalid, 1);
      check("oor_bresp",  s_axil_bresp,  EXP_BAD);
      check("oor_pulse",  wr_pulse_o,    16'h0000);
      check("oor_reg0",   reg_o[0],      32'h00005678);
      check("oor_reg2",   reg_o[2],      32'hDEADBEEF);
      check("oor_reg15",  reg_o[15],     32'h0);
      check("oor_reg0b",  reg_o[1],      32'h0);
      s_axil_bready = 1'b1;
      tick();
      s_axil_bready = 1'b0;

      // ---- unaligned 0x6 ----
      s_axil_awaddr = 32'h6; s_axil_awvalid = 1'b1;
      s_axil_wdata  = 32'hFFFFFFFF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
      tick();
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      check("una_bvalid", s_axil_bvalid, 1);
      check("una_bresp",  s_axil_bresp,  EXP_BAD);
      check("una_pulse",  wr_pulse_o,    16'h0000);
      check("una_reg1",   reg_o[1],      32'h0);
      check("una_reg0",   reg_o[0],      32'h00005678);
      s_axil_bready = 1'b1;
      tick();
      s_axil_bready = 1'b0;

      // ---- zero strobe to 0x4: OKAY, no change, no pulse ----
      s_axil_awaddr = 32'h4; s_axil_awvalid = 1'b1;
      s_axil_wdata  = 32'h55555555; s_axil_wstrb = 4'h0; s_axil_wvalid = 1'b1;
      tick();
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      check("zs_bresp", s_axil_bresp, 2'b00);
      check("zs_pulse", wr_pulse_o,   16'h0000);
      check("zs_reg1",  reg_o[1],     32'h0);
      s_axil_bready = 1'b1;
      tick();
      s_axil_bready = 1'b0;

      // ---- last register 0x3C, top lane only ----
      s_axil_awaddr = 32'h3C; s_axil_awvalid = 1'b1;
      s_axil_wdata  = 32'hA5A5A5A5; s_axil_wstrb = 4'h8; s_axil_wvalid = 1'b1;
      tick();
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      check("last_bresp", s_axil_bresp, 2'b00);
      check("last_pulse", wr_pulse_o,   16'h8000);
      check("last_reg15", reg_o[15],    32'hA5000000);
      s_axil_bready = 1'b1;
      tick();
      s_axil_bready = 1'b0;

      // ---- bready low for 10 cycles ----
      s_axil_awaddr = 32'hC; s_axil_awvalid = 1'b1;
      s_axil_wdata  = 32'hCAFEF00D; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
      tick();
      s_axil_wvalid = 1'b0;
      s_axil_awaddr = 32'h10;   // next AW already presented during the stall
      check("stall_reg3", reg_o[3], 32'hCAFEF00D);
      for (int i = 0; i < 10; i++) begin
         check("stall_bvalid",  s_axil_bvalid,  1);
         check("stall_bresp",   s_axil_bresp,   2'b00);
         check("stall_awready", s_axil_awready, 0);
         check("stall_wready",  s_axil_wready,  0);
         tick();
      end
      s_axil_bready = 1'b1;
      tick();
      s_axil_bready = 1'b0;
      check("stall_b_done",  s_axil_bvalid,  0);
      check("stall_aw_rdy",  s_axil_awready, 1);
      tick();
      s_axil_awvalid = 1'b0;
      check("next_aw_taken", s_axil_awready, 0);
      check("next_w_open",   s_axil_wready,  1);

      // ---- reset while in GOT_AW (addr 0x10 captured) ----
      aresetn = 1'b0;
      #1;
      check("mrst_bvalid",  s_axil_bvalid,  0);
      check("mrst_awready", s_axil_awready, 0);
      check("mrst_wready",  s_axil_wready,  0);
      check("mrst_reg0",    reg_o[0],       32'h0);
      check("mrst_reg3",    reg_o[3],       32'h0);
      check("mrst_reg15",   reg_o[15],      32'h0);
      tick();
      aresetn = 1'b1;
      #1;
      check("mrel_awready_pre", s_axil_awready, 0);
      tick();
      check("mrel_awready", s_axil_awready, 1);
      check("mrel_wready",  s_axil_wready,  1);
      s_axil_wdata = 32'h11111111; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
      tick();
      s_axil_wvalid = 1'b0;
      check("mw_bvalid",  s_axil_bvalid,  0);
      check("mw_pulse",   wr_pulse_o,     16'h0000);
      check("mw_wready",  s_axil_wready,  0);
      check("mw_awready", s_axil_awready, 1);
      tick();
      check("mw_bvalid2", s_axil_bvalid,  0);
      check("mw_reg4",    reg_o[4],       32'h0);
      s_axil_awaddr = 32'h14; s_axil_awvalid = 1'b1;
      tick();
      s_axil_awvalid = 1'b0;
      check("mw_done_pulse", wr_pulse_o, 16'h0020);
      check("mw_reg5",       reg_o[5],   32'h11111111);
      check("mw_reg4b",      reg_o[4],   32'h0);
      s_axil_bready = 1'b1;
      tick();
      s_axil_bready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/axil_regfile_wr.md
AXIL_REGFILE_WR -- requirements
Module: axil_regfile_wr

Interface
REQ-001 The block SHALL have parameter AXI_DATA_WIDTH, default 32, meaning the W data width in bits (multiple of 8).
REQ-002 The block SHALL have parameter AXI_ADDR_WIDTH, default 32, meaning the AW address width in bits.
REQ-003 The block SHALL have parameter NUM_REGS, default 16, meaning the register count (at least 1).
REQ-004 The block SHALL have parameter BASE_ADDR, default 0, meaning the byte address of register 0 (word-aligned).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: aclk input 1 (clock); aresetn input 1 (async active-low reset).
REQ-006 The block SHALL have the write-address ports: s_axil_awaddr input AXI_ADDR_WIDTH (byte address); s_axil_awvalid input 1; s_axil_awready output 1.
REQ-007 The block SHALL have the write-data ports: s_axil_wdata input AXI_DATA_WIDTH; s_axil_wstrb input AXI_DATA_WIDTH/8; s_axil_wvalid input 1; s_axil_wready output 1.
REQ-008 The block SHALL have the write-response ports: s_axil_bresp output 2; s_axil_bvalid output 1; s_axil_bready input 1.
REQ-009 The block SHALL have reg_o output, an unpacked array [NUM_REGS] of AXI_DATA_WIDTH, carrying current register contents.
REQ-010 The block SHALL have wr_pulse_o output NUM_REGS, a one-hot, one-cycle strobe for each register written.

Function
REQ-011 The FSM SHALL have four states: IDLE, GOT_AW, GOT_W, RESP.
REQ-012 Ready outputs SHALL be registered from state: awready=1 in IDLE and GOT_W; wready=1 in IDLE and GOT_AW; both 0 in RESP.
REQ-013 In IDLE, the FSM SHALL transition as follows: AW handshake only -> GOT_AW; W handshake only -> GOT_W; both in the same cycle -> RESP.
REQ-014 The FSM SHALL transition GOT_AW -> RESP on a W handshake, GOT_W -> RESP on an AW handshake, and RESP -> IDLE on bvalid&&bready.
REQ-015 Address and data/strobe SHALL be captured into holding registers on their own handshake edge, and AW/W SHALL be accepted in either order.
REQ-016 On the edge completing the second handshake, the decoded register SHALL be updated, wr_pulse_o SHALL pulse for exactly that cycle, and bvalid SHALL rise, giving 1-cycle latency from the last handshake to bvalid.
REQ-017 Decode SHALL compute idx = (awaddr - BASE_ADDR) >> log2(AXI_DATA_WIDTH/8).
REQ-018 An access SHALL be valid iff awaddr >= BASE_ADDR, idx < NUM_REGS, and the low log2(AXI_DATA_WIDTH/8) bits are zero; the subtraction SHALL be done at AXI_ADDR_WIDTH+1 bits so there is no wrap-around.
REQ-019 Only byte lanes with wstrb=1 SHALL change; wstrb=0 SHALL leave the register unchanged, produce no wr_pulse_o, and return OKAY.
REQ-020 An invalid access SHALL modify no register and SHALL produce no wr_pulse_o.
REQ-021 bvalid and bresp SHALL hold stable until bready is sampled high; bready held low SHALL stall indefinitely.
REQ-022 A new transaction SHALL NOT be accepted before the B handshake; the earliest next AW/W acceptance SHALL be the cycle after the B handshake.

Reset
REQ-023 On aresetn=0 the block SHALL immediately enter IDLE, and all outputs SHALL reset as follows: reg_o all 0; wr_pulse_o 0; bvalid 0; bresp 2'b00; awready 0 and wready 0 while in reset.
REQ-024 awready and wready SHALL rise on the first clock edge after reset release.
REQ-025 Reset mid-transaction SHALL discard any captured AW/W and any pending response without writing.

Configuration
REQ-026 With macro AXIL_REGFILE_WR_SLVERR_EN defined, an invalid access SHALL return bresp=2'b10 (SLVERR).
REQ-027 Without AXIL_REGFILE_WR_SLVERR_EN, an invalid access SHALL return bresp=2'b00 (OKAY) and be silently dropped; valid-access behaviour SHALL be identical in both builds.

Structure
REQ-028 Shared package axil_pkg SHALL hold the response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 and the FSM state enum type.
REQ-029 Address decode (idx plus valid flag) SHALL be a combinational sub-module, axil_regfile_decode, instantiated once.

Verification
REQ-030 Bench SHALL cover simultaneous AW and W: awaddr=0x8, wdata=0xDEADBEEF, wstrb=4'hF -> bvalid one cycle later, bresp=OKAY, reg_o[2]=0xDEADBEEF, wr_pulse_o=16'h0004 for 1 cycle.
REQ-031 Bench SHALL cover W three cycles before AW (0x0, 0x12345678, strb 4'h3) -> reg_o[0]=0x00005678, awready held 1 while in GOT_W.
REQ-032 Bench SHALL cover an out-of-range write to 0x40 with NUM_REGS=16 -> SLVERR when the macro is defined, OKAY otherwise; all reg_o unchanged and no wr_pulse_o.
REQ-033 Bench SHALL cover an unaligned write to 0x6 -> same response as REQ-032 and no register change.
REQ-034 Bench SHALL cover bready held low for 10 cycles -> bvalid and bresp stable, awready=wready=0 throughout, with the next AW accepted the cycle after the B handshake.
REQ-035 Bench SHALL cover aresetn asserted while in GOT_AW -> bvalid=0, reg_o all 0, a subsequent W alone causing no write, and ready outputs returning one edge after release.
